ir_sequencer: RTL and testbench

IR_SEQUENCER -- requirements
Module: ir_sequencer

---
 rtl/ir_sequencer_if.sv | 37 +++
 rtl/ir_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ir_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_sequencer_if.sv
// Bundle of the program-load stream, fetch controls, instruction output and IR store
// drive for ir_sequencer. master = sequencer side, slave = surrounding environment.
interface ir_sequencer_if #(
  parameter int IRR_WIDTH     = 16,
  parameter int IR_ADDR_WIDTH = 4
);
  // Handshakes (ld_*, ins_*): a word moves on a rising edge where valid && ready are both
  // high. The source holds valid and payload stable until that edge, and ready may depend
  // combinationally on the receiver's state but never on valid.
  logic                     ld_valid;
  logic                     ld_ready;
  logic                     ld_last;
  logic [IRR_WIDTH-1:0]     ld_data;
  logic                     start;
  logic                     jmp_valid;
  logic [IR_ADDR_WIDTH-1:0] jmp_addr;
  logic                     ins_valid;
  logic                     ins_ready;
  logic [IRR_WIDTH-1:0]     ins_data;
  logic [IR_ADDR_WIDTH-1:0] ins_pc;
  logic [IR_ADDR_WIDTH-1:0] ir_addr;
  logic                     ir_mode;
  logic [IRR_WIDTH-1:0]     ir_wdata;
  logic [IRR_WIDTH-1:0]     ir_rdata;
  logic                     busy;
  logic                     done;

  modport master (
    input  ld_valid, ld_last, ld_data, start, jmp_valid, jmp_addr, ins_ready, ir_rdata,
    output ld_ready, ins_valid, ins_data, ins_pc, ir_addr, ir_mode, ir_wdata, busy, done
  );

  modport slave (
    output ld_valid, ld_last, ld_data, start, jmp_valid, jmp_addr, ins_ready, ir_rdata,
    input  ld_ready, ins_valid, ins_data, ins_pc, ir_addr, ir_mode, ir_wdata, busy, done
  );
endinterface

// File: rtl/ir_sequencer.sv
// Loads a program into an external IR store while idle, then fetches it word by word
// (address, wait, output) with jump redirection and an end-of-program done pulse.
module ir_sequencer #(
  parameter int IRR_WIDTH     = 16,
  parameter int IR_ADDR_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ir_sequencer_if.master bus,
  output logic [1:0]     dbg_state
);
  localparam int AW    = IR_ADDR_WIDTH;
  localparam int LW    = IR_ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** IR_ADDR_WIDTH;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F_ADDR = 2'd1,
    F_WAIT = 2'd2,
    F_OUT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        pc_q, pc_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        prog_len_q, prog_len_d;
  logic [AW-1:0]        ir_addr_q, ir_addr_d;
  logic                 ir_mode_q, ir_mode_d;
  logic [IRR_WIDTH-1:0] ir_wdata_q, ir_wdata_d;
  logic [IRR_WIDTH-1:0] ins_data_q, ins_data_d;
  logic [AW-1:0]        ins_pc_q, ins_pc_d;
  logic                 done_q, done_d;

  logic          idle, ld_ready_w, ld_fire;
  logic          start_go, start_empty;
  logic          jmp_hit, jmp_ok, hs, last_hs;
  logic [LW-1:0] pc_inc, cnt_inc;

  assign idle        = (state_q == IDLE);
  assign ld_ready_w  = rst_n && idle && !bus.start;
  assign ld_fire     = ld_ready_w && bus.ld_valid;
  assign start_go    = idle && bus.start && (prog_len_q != '0);
  assign start_empty = idle && bus.start && (prog_len_q == '0);
  // A jump outranks the output handshake in every fetch state.
  assign jmp_hit     = !idle && bus.jmp_valid;
  assign jmp_ok      = ({1'b0, bus.jmp_addr} < prog_len_q);
  assign hs          = (state_q == F_OUT) && bus.ins_ready && !bus.jmp_valid;
  assign pc_inc      = {1'b0, pc_q} + LW'(1);
  assign last_hs     = hs && (pc_inc == prog_len_q);
  // Beat count saturates so an over-long load reports a full store.
  assign cnt_inc     = (cnt_q == DEPTH_L) ? cnt_q : cnt_q + LW'(1);

  // State register (plus the datapath flops it steers).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
      prog_len_q <= '0;
      ir_addr_q  <= '0;
      ir_mode_q  <= 1'b0;
      ir_wdata_q <= '0;
      ins_data_q <= '0;
      ins_pc_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      prog_len_q <= prog_len_d;
      ir_addr_q  <= ir_addr_d;
      ir_mode_q  <= ir_mode_d;
      ir_wdata_q <= ir_wdata_d;
      ins_data_q <= ins_data_d;
      ins_pc_q   <= ins_pc_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (jmp_hit) begin
      state_d = jmp_ok ? F_ADDR : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_go) state_d = F_ADDR;
        F_ADDR:  state_d = F_WAIT;
        F_WAIT:  state_d = F_OUT;
        F_OUT:   if (hs) state_d = last_hs ? IDLE : F_ADDR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath logic.
  always_comb begin
    pc_d       = pc_q;
    wptr_d     = wptr_q;
    cnt_d      = cnt_q;
    prog_len_d = prog_len_q;
    ir_addr_d  = ir_addr_q;
    ir_mode_d  = 1'b0;
    ir_wdata_d = ir_wdata_q;
    ins_data_d = ins_data_q;
    ins_pc_d   = ins_pc_q;
    done_d     = 1'b0;

    if (ld_fire) begin
      ir_mode_d  = 1'b1;
      ir_addr_d  = wptr_q;
      ir_wdata_d = bus.ld_data;
      if (bus.ld_last) begin
        prog_len_d = cnt_inc;
        cnt_d      = '0;
        wptr_d     = '0;
      end else begin
        cnt_d  = cnt_inc;
        wptr_d = wptr_q + AW'(1);
      end
    end

    if (start_go) begin
      pc_d      = '0;
      ir_addr_d = '0;
    end
    if (start_empty) done_d = 1'b1;

    if (jmp_hit) begin
      if (jmp_ok) begin
        pc_d      = bus.jmp_addr;
        ir_addr_d = bus.jmp_addr;
      end else begin
        done_d = 1'b1;
      end
    end else if (state_q == F_WAIT) begin
      ins_data_d = bus.ir_rdata;
      ins_pc_d   = pc_q;
    end else if (hs) begin
      if (last_hs) begin
        done_d = 1'b1;
      end else begin
        pc_d      = pc_inc[AW-1:0];
        ir_addr_d = pc_inc[AW-1:0];
      end
    end
  end

  assign bus.ld_ready  = ld_ready_w;
  assign bus.ins_valid = (state_q == F_OUT);
  assign bus.busy      = !idle;
  assign bus.done      = done_q;
  assign bus.ins_data  = ins_data_q;
  assign bus.ins_pc    = ins_pc_q;
  assign bus.ir_addr   = ir_addr_q;
  assign bus.ir_mode   = ir_mode_q;
  assign bus.ir_wdata  = ir_wdata_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_ir_sequencer.sv
// Bench for ir_sequencer: a behavioural IR store, per-scenario tasks with inline checks,
// and a scoreboard that pairs expected {pc, word} entries with output handshakes.
module tb_ir_sequencer;
  localparam int W  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  ir_sequencer_if #(.IRR_WIDTH(W), .IR_ADDR_WIDTH(AW)) bus();

  ir_sequencer #(.IRR_WIDTH(W), .IR_ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // IR store: write on ir_mode, registered read of the sampled address.
  logic [W-1:0] mem [16];
  always @(posedge clk) begin
    if (bus.ir_mode) mem[bus.ir_addr] <= bus.ir_wdata;
    bus.ir_rdata <= mem[bus.ir_addr];
  end

  logic [AW+W-1:0] exp_q[$];
  logic [AW+W-1:0] mon_exp;
  logic [W-1:0]    prog_words [32];
  int checks = 0;
  int passes = 0;

  always @(negedge clk) begin
    if (rst_n && bus.ins_valid && bus.ins_ready && !bus.jmp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got pc %0d data %h, want no output", bus.ins_pc, bus.ins_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.ins_pc, bus.ins_data} !== mon_exp)
          $display("FAIL sb_word: got pc %0d data %h, want pc %0d data %h",
                   bus.ins_pc, bus.ins_data, mon_exp[AW+W-1:W], mon_exp[W-1:0]);
        else passes++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int pc, input logic [W-1:0] word);
    exp_q.push_back({AW'(pc), word});
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (bus.done) seen = 1;
    end
    checks++; if (!seen) $display("FAIL %s_done: got no done in %0d cycles, want done", name, budget); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d pending words, want 0", name, exp_q.size()); else passes++;
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i <= n; i++) begin
      step();
      if (i > 0) begin
        checks++; if (bus.ir_mode !== 1'b1) $display("FAIL load_mode[%0d]: got %b want 1", i-1, bus.ir_mode); else passes++;
        checks++; if (bus.ir_addr !== AW'((i-1) % 16)) $display("FAIL load_addr[%0d]: got %0d want %0d", i-1, bus.ir_addr, (i-1) % 16); else passes++;
        checks++; if (bus.ir_wdata !== prog_words[i-1]) $display("FAIL load_wdata[%0d]: got %h want %h", i-1, bus.ir_wdata, prog_words[i-1]); else passes++;
      end
      if (i < n) begin
        bus.ld_valid = 1'b1;
        bus.ld_data  = prog_words[i];
        bus.ld_last  = (i == n-1);
        @(negedge clk);
        checks++; if (bus.ld_ready !== 1'b1) $display("FAIL load_ready[%0d]: got %b want 1", i, bus.ld_ready); else passes++;
      end else begin
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
      end
    end
    step();
    checks++; if (bus.ir_mode !== 1'b0) $display("FAIL load_mode_off: got %b want 0", bus.ir_mode); else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ld_valid = 1'b1; bus.start = 1'b1; bus.ld_data = 16'hDEAD;
    step(); step();
    checks++; if (bus.ins_valid !== 1'b0) $display("FAIL rst_ins_valid: got %b want 0", bus.ins_valid); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else passes++;
    checks++; if (bus.ir_mode !== 1'b0) $display("FAIL rst_ir_mode: got %b want 0", bus.ir_mode); else passes++;
    checks++; if (bus.ir_addr !== '0) $display("FAIL rst_ir_addr: got %0d want 0", bus.ir_addr); else passes++;
    checks++; if (bus.ins_data !== '0) $display("FAIL rst_ins_data: got %h want 0", bus.ins_data); else passes++;
    checks++; if (bus.ins_pc !== '0) $display("FAIL rst_ins_pc: got %0d want 0", bus.ins_pc); else passes++;
    checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else passes++;
    @(negedge clk);
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL rst_ld_ready: got %b want 0", bus.ld_ready); else passes++;
    step();
    rst_n = 1'b1; bus.ld_valid = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.ld_ready !== 1'b1) $display("FAIL idle_ld_ready: got %b want 1", bus.ld_ready); else passes++;
  endtask

  task automatic test_empty_start();
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1) $display("FAIL empty_done: got %b want 1", bus.done); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL empty_busy: got %b want 0", bus.busy); else passes++;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.done !== 1'b0) $display("FAIL empty_done_clear[%0d]: got %b want 0", k, bus.done); else passes++;
      checks++; if (bus.ins_valid !== 1'b0) $display("FAIL empty_ins_valid[%0d]: got %b want 0", k, bus.ins_valid); else passes++;
    end
  endtask

  task automatic test_fetch();
    prog_words[0] = 16'h1111; prog_words[1] = 16'h2222; prog_words[2] = 16'h3333;
    load_words(3);
    bus.ins_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(i, prog_words[i]);
    bus.start = 1'b1;
    @(negedge clk);
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL fetch_ld_ready: got %b want 0", bus.ld_ready); else passes++;
    step();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) $display("FAIL fetch_busy_rise: got %b want 1", bus.busy); else passes++;
    checks++; if (bus.ir_addr !== '0) $display("FAIL fetch_ir_addr: got %0d want 0", bus.ir_addr); else passes++;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (bus.ins_valid !== (k == 2 || k == 5 || k == 8)) $display("FAIL fetch_valid[%0d]: got %b want %b", k, bus.ins_valid, (k == 2 || k == 5 || k == 8)); else passes++;
      checks++; if (bus.done !== (k == 9)) $display("FAIL fetch_done[%0d]: got %b want %b", k, bus.done, (k == 9)); else passes++;
      checks++; if (bus.busy !== (k < 9)) $display("FAIL fetch_busy[%0d]: got %b want %b", k, bus.busy, (k < 9)); else passes++;
      checks++; if (bus.ir_mode !== 1'b0) $display("FAIL fetch_ir_mode[%0d]: got %b want 0", k, bus.ir_mode); else passes++;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL fetch_drain: got %0d pending, want 0", exp_q.size()); else passes++;
  endtask

  task automatic test_stall_jump();
    bus.ins_ready = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    for (int k = 0; k <= 5; k++) begin
      checks++; if (bus.ins_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", k, bus.ins_valid); else passes++;
      checks++; if (bus.ins_data !== 16'h1111) $display("FAIL stall_data[%0d]: got %h want 1111", k, bus.ins_data); else passes++;
      checks++; if (bus.ins_pc !== '0) $display("FAIL stall_pc[%0d]: got %0d want 0", k, bus.ins_pc); else passes++;
      if (k < 5) step();
    end
    bus.jmp_valid = 1'b1; bus.jmp_addr = '0; bus.ins_ready = 1'b1;
    push_exp(0, 16'h1111); push_exp(1, 16'h2222); push_exp(2, 16'h3333);
    step();
    bus.jmp_valid = 1'b0;
    checks++; if (bus.ins_valid !== 1'b0) $display("FAIL jump_drop_valid: got %b want 0", bus.ins_valid); else passes++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL jump_busy: got %b want 1", bus.busy); else passes++;
    step(); step();
    checks++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== '0) $display("FAIL jump_refetch: got valid %b pc %0d want valid 1 pc 0", bus.ins_valid, bus.ins_pc); else passes++;
    wait_done("stall_jump", 20);
  endtask

  task automatic test_jump_out_of_range();
    bus.ins_ready = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.jmp_valid = 1'b1; bus.jmp_addr = 4'd5;
    step();
    bus.jmp_valid = 1'b0;
    checks++; if (bus.done !== 1'b1) $display("FAIL jmp_oor_done: got %b want 1", bus.done); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL jmp_oor_busy: got %b want 0", bus.busy); else passes++;
    step();
    checks++; if (bus.done !== 1'b0 || bus.ins_valid !== 1'b0) $display("FAIL jmp_oor_after: got done %b valid %b want 0 0", bus.done, bus.ins_valid); else passes++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) prog_words[i] = 16'hA000 + 16'(i);
    load_words(17);
    bus.ins_ready = 1'b1;
    push_exp(15, 16'hA00F);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.jmp_valid = 1'b1; bus.jmp_addr = 4'd15;
    step();
    bus.jmp_valid = 1'b0;
    wait_done("wrap_jump15", 20);
    push_exp(0, 16'hA010);
    for (int i = 1; i < 16; i++) push_exp(i, 16'hA000 + 16'(i));
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("wrap_full", 80);
  endtask

  task automatic test_start_priority_and_reset();
    bus.ins_ready = 1'b0;
    step();
    bus.start = 1'b1; bus.ld_valid = 1'b1; bus.ld_data = 16'hBEEF; bus.ld_last = 1'b1;
    @(negedge clk);
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL prio_ld_ready: got %b want 0", bus.ld_ready); else passes++;
    step();
    bus.start = 1'b0; bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    checks++; if (bus.ir_mode !== 1'b0) $display("FAIL prio_ir_mode: got %b want 0", bus.ir_mode); else passes++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL prio_busy: got %b want 1", bus.busy); else passes++;
    step(); step();
    checks++; if (bus.ins_valid !== 1'b1 || bus.ins_data !== 16'hA010) $display("FAIL prio_word0: got valid %b data %h want 1 a010", bus.ins_valid, bus.ins_data); else passes++;
    rst_n = 1'b0;
    step();
    checks++; if (bus.ins_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bus.ins_valid); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL midrst_ld_ready: got %b want 0", bus.ld_ready); else passes++;
    checks++; if (bus.ins_data !== '0 || bus.ins_pc !== '0) $display("FAIL midrst_ins: got data %h pc %0d want 0 0", bus.ins_data, bus.ins_pc); else passes++;
    checks++; if (bus.ir_wdata !== '0 || bus.ir_addr !== '0 || bus.ir_mode !== 1'b0) $display("FAIL midrst_ir: got wdata %h addr %0d mode %b want 0 0 0", bus.ir_wdata, bus.ir_addr, bus.ir_mode); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b want 0", bus.done); else passes++;
    rst_n = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) $display("FAIL midrst_len_lost: got done %b busy %b want 1 0", bus.done, bus.busy); else passes++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.ld_data = '0;
    bus.start = 1'b0; bus.jmp_valid = 1'b0; bus.jmp_addr = '0; bus.ins_ready = 1'b0;
    test_reset();
    test_empty_start();
    test_fetch();
    test_stall_jump();
    test_jump_out_of_range();
    test_wrap();
    test_start_priority_and_reset();
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
